// File: rtl/stereolbm_arith_pkg.sv
// Shared fixed-point helpers for the stereo LBM datapath: rounding shift, signed clipping,
// accumulate-mode decode and the accumulator width guard.
`ifndef STEREOLBM_ARITH_PKG_SV
`define STEREOLBM_ARITH_PKG_SV

// Elaboration guard: the accumulator must hold a full product plus one bit of headroom.
`define STEREOLBM_CHECK_ACC_WIDTH(aw, w0, w1) \
  if (((aw) < (w0) + (w1) + 1) || ((aw) + 1 > stereolbm_arith_pkg::ARITH_MAXW)) begin : g_acc_width_bad \
    $error("ACC_WIDTH out of range for operand widths"); \
  end

package stereolbm_arith_pkg;

  localparam int unsigned ARITH_MAXW = 256;

  typedef logic signed [ARITH_MAXW-1:0] wide_t;

  typedef enum logic [1:0] {
    ACC_PASS = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_LOAD = 2'd2
  } acc_mode_e;

  function automatic acc_mode_e acc_mode(input logic clr, input logic en);
    if (clr) return ACC_LOAD;
    if (en) return ACC_ADD;
    return ACC_PASS;
  endfunction

  // Round half up, then arithmetic shift; the wide working width means the bias cannot wrap.
  function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
    wide_t half;
    half = '0;
    if (sh > 0) half = wide_t'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic wide_t sat_signed(input wide_t v, input int unsigned w, output logic clipped);
    wide_t lo;
    wide_t hi;
    lo = '1;
    lo = lo <<< (w - 1);
    hi = ~lo;
    clipped = 1'b0;
    if (v > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

`endif

// File: rtl/stereolbm_axis_cambm_mac_pipe_if.sv
// Operand/result bundle of the MAC pipe; master drives operands, slave returns results.
interface stereolbm_axis_cambm_mac_pipe_if #(
  parameter int din0_WIDTH = 33,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 52
);
  logic                  in_valid;
  logic                  acc_en;
  logic                  acc_clr;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [dout_WIDTH-1:0] dout;
  logic                  sat;
  logic                  acc_ovf;

  modport master (
    output in_valid, acc_en, acc_clr, din0, din1,
    input  out_valid, dout, sat, acc_ovf
  );

  modport slave (
    input  in_valid, acc_en, acc_clr, din0, din1,
    output out_valid, dout, sat, acc_ovf
  );
endinterface

// File: rtl/stereolbm_pipe_dly.sv
// Clock-enabled delay line with synchronous clear; DEPTH registers of WIDTH bits.
module stereolbm_pipe_dly #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else if (ce) begin
      stg[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign dout = stg[DEPTH-1];
endmodule

// File: rtl/stereolbm_axis_cambm_mac_pipe.sv
// Pipelined multiply / multiply-accumulate with rounding shift and output saturation.
// Product and sideband travel NUM_STAGE registers, then one post stage updates acc and dout.
module stereolbm_axis_cambm_mac_pipe
  import stereolbm_arith_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 33,
  parameter int din1_WIDTH  = 32,
  parameter int dout_WIDTH  = 52,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 1,
  parameter int ACC_WIDTH   = 72,
  parameter int SHIFT       = 0,
  parameter int SATURATE    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  stereolbm_axis_cambm_mac_pipe_if.slave bus
);
  localparam int PW     = din0_WIDTH + din1_WIDTH;
  localparam int PIPE_W = PW + 4;

  `STEREOLBM_CHECK_ACC_WIDTH(ACC_WIDTH, din0_WIDTH, din1_WIDTH)

  logic signed [din0_WIDTH:0] op0;
  logic signed [din1_WIDTH:0] op1;
  logic signed [PW+1:0]       prod_full;
  logic signed [PW:0]         prod;
  logic [PIPE_W-1:0]          pipe_in;
  logic [PIPE_W-1:0]          pipe_out;

  // One extra bit per operand makes signed and unsigned operands share a single signed multiply.
  always_comb begin
    op0       = {(din0_SIGNED != 0) & bus.din0[din0_WIDTH-1], bus.din0};
    op1       = {(din1_SIGNED != 0) & bus.din1[din1_WIDTH-1], bus.din1};
    prod_full = op0 * op1;
    prod      = prod_full[PW:0];
    pipe_in   = {bus.in_valid, bus.acc_en, bus.acc_clr, prod};
  end

  stereolbm_pipe_dly #(
    .WIDTH(PIPE_W),
    .DEPTH(NUM_STAGE)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  logic                  d_valid;
  logic                  d_en;
  logic                  d_clr;
  logic signed [PW:0]    d_prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc_n;
  logic                  ovf_q;
  logic                  ovf_n;
  logic                  sat_q;
  logic                  sat_n;
  logic                  out_valid_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic [dout_WIDTH-1:0] dout_n;
  wide_t                 rounded;
  wide_t                 clipped;
  acc_mode_e             mode;
  logic                  unused_bits;

  // Output is derived from the freshly updated accumulator so back-to-back adds never stall.
  always_comb begin
    d_valid = pipe_out[PIPE_W-1];
    d_en    = pipe_out[PIPE_W-2];
    d_clr   = pipe_out[PIPE_W-3];
    d_prod  = pipe_out[PW:0];
    p_ext   = ACC_WIDTH'(d_prod);
    sum     = acc_q + p_ext;
    mode    = acc_mode(d_clr, d_en);
    acc_n   = p_ext;
    ovf_n   = ovf_q;
    case (mode)
      ACC_LOAD: ovf_n = 1'b0;
      ACC_ADD: begin
        acc_n = sum;
        ovf_n = ovf_q | ((acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                         (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]));
      end
      default: ;
    endcase
    rounded = round_shift(wide_t'(acc_n), SHIFT);
    clipped = rounded;
    sat_n   = 1'b0;
    if (SATURATE != 0) clipped = sat_signed(rounded, dout_WIDTH, sat_n);
    dout_n  = clipped[dout_WIDTH-1:0];
  end

  assign unused_bits = ^{clipped[ARITH_MAXW-1:dout_WIDTH], prod_full[PW+1], 32'(ID)};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (ce) begin
      out_valid_q <= d_valid;
      if (d_valid) begin
        acc_q  <= acc_n;
        ovf_q  <= ovf_n;
        dout_q <= dout_n;
        sat_q  <= sat_n;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;
  assign bus.acc_ovf   = ovf_q;
endmodule

// File: tb/tb_stereolbm_axis_cambm_mac_pipe.sv
// Bench for the MAC pipe: four parameterisations driven from one directed/random sequence,
// checked every cycle against an exact-arithmetic model with a latency-stamped expectation queue.
module tb_stereolbm_axis_cambm_mac_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  always #5 clk = ~clk;

  localparam int LAT = 3;
  localparam int SH [4] = '{0, 0, 4, 0};
  localparam int DW [4] = '{52, 16, 52, 52};
  localparam int SG [4] = '{1, 1, 1, 0};

  stereolbm_axis_cambm_mac_pipe_if                     if_a ();
  stereolbm_axis_cambm_mac_pipe_if #(.dout_WIDTH(16))  if_b ();
  stereolbm_axis_cambm_mac_pipe_if                     if_c ();
  stereolbm_axis_cambm_mac_pipe_if                     if_d ();

  stereolbm_axis_cambm_mac_pipe u_a (.clk(clk), .reset(reset), .ce(ce), .bus(if_a));
  stereolbm_axis_cambm_mac_pipe #(.dout_WIDTH(16), .SHIFT(0)) u_b (.clk(clk), .reset(reset), .ce(ce), .bus(if_b));
  stereolbm_axis_cambm_mac_pipe #(.SHIFT(4)) u_c (.clk(clk), .reset(reset), .ce(ce), .bus(if_c));
  stereolbm_axis_cambm_mac_pipe #(.din0_SIGNED(0), .din1_SIGNED(0)) u_d (.clk(clk), .reset(reset), .ce(ce), .bus(if_d));

  typedef struct {
    int unsigned        due;
    logic signed [63:0] d;
    bit                 s;
    bit                 o;
  } exp_t;

  exp_t               q [4][$];
  logic signed [127:0] macc [4];
  bit                 movf [4];
  bit                 last_v [4];
  logic signed [63:0] last_d [4];
  bit                 last_s [4];
  bit                 last_o [4];
  int unsigned        cyc;
  int                 checks;
  int                 failures;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] ext(input logic [32:0] x, input int w, input bit sg);
    logic signed [127:0] r;
    r = '0;
    r[32:0] = x;
    r = r & ((128'sd1 <<< w) - 128'sd1);
    if (sg && x[w-1]) r = r - (128'sd1 <<< w);
    return r;
  endfunction

  function automatic logic signed [127:0] wrap72(input logic signed [127:0] x);
    logic signed [127:0] t;
    t = x <<< 56;
    t = t >>> 56;
    return t;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      macc[k] = '0;
      movf[k] = 1'b0;
      last_v[k] = 1'b0;
      last_d[k] = '0;
      last_s[k] = 1'b0;
      last_o[k] = 1'b0;
    end
  endtask

  task automatic model_issue(input int k, input logic [32:0] a, input logic [31:0] b, input bit en, input bit clr);
    logic signed [127:0] p, s, w, r, hi, lo;
    bit clip;
    p = ext(a, 33, SG[k] != 0) * ext({1'b0, b}, 32, SG[k] != 0);
    if (clr) begin
      macc[k] = p;
      movf[k] = 1'b0;
    end else if (en) begin
      s = macc[k] + p;
      w = wrap72(s);
      if (w != s) movf[k] = 1'b1;
      macc[k] = w;
    end else begin
      macc[k] = p;
    end
    r = macc[k];
    if (SH[k] > 0) r = r + (128'sd1 <<< (SH[k] - 1));
    r = r >>> SH[k];
    hi = (128'sd1 <<< (DW[k] - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    clip = 1'b0;
    if (r > hi) begin r = hi; clip = 1'b1; end
    else if (r < lo) begin r = lo; clip = 1'b1; end
    q[k].push_back('{cyc + LAT, 64'(r), clip, movf[k]});
  endtask

  task automatic set_in(input int k, input logic v, input logic [32:0] a, input logic [31:0] b,
                        input logic en, input logic clr);
    case (k)
      0: begin if_a.in_valid = v; if_a.din0 = a; if_a.din1 = b; if_a.acc_en = en; if_a.acc_clr = clr; end
      1: begin if_b.in_valid = v; if_b.din0 = a; if_b.din1 = b; if_b.acc_en = en; if_b.acc_clr = clr; end
      2: begin if_c.in_valid = v; if_c.din0 = a; if_c.din1 = b; if_c.acc_en = en; if_c.acc_clr = clr; end
      default: begin if_d.in_valid = v; if_d.din0 = a; if_d.din1 = b; if_d.acc_en = en; if_d.acc_clr = clr; end
    endcase
  endtask

  task automatic sample(input int k, output logic ov, output logic signed [63:0] d, output logic s, output logic o);
    case (k)
      0: begin ov = if_a.out_valid; d = 64'(signed'(if_a.dout)); s = if_a.sat; o = if_a.acc_ovf; end
      1: begin ov = if_b.out_valid; d = 64'(signed'(if_b.dout)); s = if_b.sat; o = if_b.acc_ovf; end
      2: begin ov = if_c.out_valid; d = 64'(signed'(if_c.dout)); s = if_c.sat; o = if_c.acc_ovf; end
      default: begin ov = if_d.out_valid; d = 64'(signed'(if_d.dout)); s = if_d.sat; o = if_d.acc_ovf; end
    endcase
  endtask

  task automatic tick();
    logic ce_e, rst_e, ov, s, o;
    logic signed [63:0] d;
    exp_t e;
    ce_e = ce;
    rst_e = reset;
    @(posedge clk);
    #1;
    if (rst_e) begin
      model_reset();
    end else if (ce_e) begin
      cyc++;
      for (int k = 0; k < 4; k++) begin
        last_v[k] = 1'b0;
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
          e = q[k].pop_front();
          last_v[k] = 1'b1;
          last_d[k] = e.d;
          last_s[k] = e.s;
          last_o[k] = e.o;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      sample(k, ov, d, s, o);
      chk($sformatf("out_valid[%0d]@%0d", k, cyc), 64'(ov), 64'(last_v[k]));
      chk($sformatf("dout[%0d]@%0d", k, cyc), d, last_d[k]);
      chk($sformatf("sat[%0d]@%0d", k, cyc), 64'(s), 64'(last_s[k]));
      chk($sformatf("acc_ovf[%0d]@%0d", k, cyc), 64'(o), 64'(last_o[k]));
    end
  endtask

  task automatic drive(input int k, input bit v, input logic [32:0] a, input logic [31:0] b,
                       input bit en, input bit clr, input bit cev);
    for (int j = 0; j < 4; j++)
      set_in(j, 1'b0, 33'($urandom()), $urandom(), 1'b1, ($urandom_range(0, 1) == 1));
    set_in(k, v, a, b, en, clr);
    ce = cev;
    if (v && cev && !reset) model_issue(k, a, b, en, clr);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    cyc = 0;
    checks = 0;
    failures = 0;
    model_reset();
    for (int k = 0; k < 4; k++) set_in(k, 1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // single pass-through product, latency visible as out_valid position
    drive(0, 1'b1, 33'h1_FFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b1);
    idle(4);

    // stream with a two-cycle ce stall carrying garbage valid inputs
    for (int i = 1; i <= 6; i++) begin
      drive(0, 1'b1, 33'(i), 32'(i), 1'b0, 1'b0, 1'b1);
      if (i == 3) begin
        drive(0, 1'b1, 33'd99, 32'd99, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b1, 33'd77, 32'd77, 1'b1, 1'b0, 1'b0);
      end
    end
    idle(4);

    // clear / accumulate / bubble / accumulate
    drive(0, 1'b1, 33'd5, 32'd6, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 33'd2, 32'd3, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b0, 33'd9, 32'd9, 1'b1, 1'b0, 1'b1);
    drive(0, 1'b1, 33'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    idle(4);

    // 16-bit saturation, round-half-up shift, unsigned operands
    drive(1, 1'b1, 33'd300, 32'd300, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b1, 33'h1_FFFF_FED4, 32'd300, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b1, 33'd100, 32'd100, 1'b0, 1'b0, 1'b1);
    drive(2, 1'b1, 33'd3, 32'd8, 1'b0, 1'b0, 1'b1);
    drive(2, 1'b1, 33'h1_FFFF_FFFD, 32'd8, 1'b0, 1'b0, 1'b1);
    drive(2, 1'b1, 33'd1, 32'd8, 1'b0, 1'b0, 1'b1);
    drive(3, 1'b1, 33'h1_FFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1);
    drive(3, 1'b1, 33'h1_0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    idle(4);

    // drive the accumulator past 2^71 to set the sticky overflow flag
    drive(0, 1'b1, 33'h1_0000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 259; i++) drive(0, 1'b1, 33'h1_0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    idle(4);

    // reset with two samples in flight, asserted while ce is low
    drive(0, 1'b1, 33'd11, 32'd13, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b1, 33'd17, 32'd19, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(4);
    drive(0, 1'b1, 33'd3, 32'd5, 1'b1, 1'b0, 1'b1);
    idle(4);

    // randomized traffic across all instances
    for (int i = 0; i < 400; i++) begin
      logic [63:0] r64;
      logic [32:0] a;
      logic [31:0] b;
      int k;
      r64 = {$urandom(), $urandom()};
      k = int'($urandom_range(0, 3));
      a = r64[32:0];
      b = $urandom();
      if ($urandom_range(0, 2) == 0) begin
        a = 33'($urandom_range(0, 40)) - 33'd20;
        b = 32'($urandom_range(0, 40)) - 32'd20;
      end
      drive(k, ($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0));
    end

    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 20) begin
      idle(1);
      n++;
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("pending[%0d]", k), 64'(q[k].size()), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
